// File: rtl/controlador_recepcao_uart_pkg.sv
// controlador_recepcao_uart_pkg: states, framing constants and checksum shared by the UART controllers.
package controlador_recepcao_uart_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        LINHA,
        COLUNA,
        VALOR,
        CHECKSUM,
        ENTREGAR
    } estado_t;

    localparam logic [7:0] SYNC_BYTE_PADRAO = 8'hA5;
    localparam logic [7:0] MAX_COORD        = 8'd8;
    localparam logic [7:0] MAX_VALOR        = 8'd9;

    function automatic logic [7:0] calc_checksum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return a ^ b ^ c;
    endfunction

endpackage

// File: rtl/controlador_recepcao_uart_contador_timeout.sv
// contador_timeout: idle-cycle counter with clear, enable and a terminal flag at LIMITE-1.
module contador_timeout #(
    parameter int WIDTH  = 16,
    parameter int LIMITE = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    logic [WIDTH-1:0] r_count;

    assign o_terminal = (r_count == WIDTH'(LIMITE - 1));

    // Holds at the terminal value so it never wraps while idle outside a packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable && !o_terminal)
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/controlador_recepcao_uart.sv
// controlador_recepcao_uart: parses SYNC,row,col,value,checksum packets from a UART
// receiver into a held command with ready/valid handshake and error reporting.
module controlador_recepcao_uart
    import controlador_recepcao_uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_PADRAO,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_done,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_error,
    input  logic       i_cmd_ready,
    output logic       o_cmd_valid,
    output logic [3:0] o_cmd_row,
    output logic [3:0] o_cmd_col,
    output logic [3:0] o_cmd_value,
    output logic       o_erro_pacote,
    output logic       o_overrun,
    output logic [7:0] o_erro_count
);

    estado_t    r_state;
    logic [3:0] r_row;
    logic [3:0] r_col;
    logic [3:0] r_valor;
    logic       r_cmd_valid;
    logic [3:0] r_cmd_row;
    logic [3:0] r_cmd_col;
    logic [3:0] r_cmd_value;
    logic       r_erro_pacote;
    logic       r_overrun;
    logic [7:0] r_erro_count;
    logic       w_timeout;
    logic       w_contando;
    logic       w_erro;
    logic [7:0] w_chk;

    assign w_contando = (r_state == LINHA) || (r_state == COLUNA) || (r_state == VALOR) || (r_state == CHECKSUM);
    assign w_chk      = calc_checksum({4'd0, r_row}, {4'd0, r_col}, {4'd0, r_valor});

    // Entering LINHA always coincides with an rx_done, so rx_done alone covers both clears.
    contador_timeout #(
        .WIDTH (16),
        .LIMITE(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_rx_done),
        .i_enable  (w_contando),
        .o_terminal(w_timeout)
    );

    // A byte in the same cycle as the terminal count wins over the timeout.
    always_comb begin
        w_erro = 1'b0;
        case (r_state)
            LINHA, COLUNA: w_erro = i_rx_done ? (i_rx_error || i_rx_data > MAX_COORD) : w_timeout;
            VALOR:         w_erro = i_rx_done ? (i_rx_error || i_rx_data > MAX_VALOR) : w_timeout;
            CHECKSUM:      w_erro = i_rx_done ? (i_rx_error || i_rx_data != w_chk) : w_timeout;
            default:       w_erro = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= OCIOSO;
            r_row         <= '0;
            r_col         <= '0;
            r_valor       <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_row     <= '0;
            r_cmd_col     <= '0;
            r_cmd_value   <= '0;
            r_erro_pacote <= 1'b0;
            r_overrun     <= 1'b0;
            r_erro_count  <= '0;
        end else begin
            r_erro_pacote <= w_erro;
            r_overrun     <= (r_state == ENTREGAR) && i_rx_done;
            if (w_erro && r_erro_count != 8'hFF)
                r_erro_count <= r_erro_count + 8'd1;
            if (w_erro)
                r_state <= OCIOSO;
            else begin
                case (r_state)
                    OCIOSO:
                        if (i_rx_done && !i_rx_error && i_rx_data == SYNC_BYTE)
                            r_state <= LINHA;
                    LINHA:
                        if (i_rx_done) begin
                            r_row   <= i_rx_data[3:0];
                            r_state <= COLUNA;
                        end
                    COLUNA:
                        if (i_rx_done) begin
                            r_col   <= i_rx_data[3:0];
                            r_state <= VALOR;
                        end
                    VALOR:
                        if (i_rx_done) begin
                            r_valor <= i_rx_data[3:0];
                            r_state <= CHECKSUM;
                        end
                    CHECKSUM:
                        if (i_rx_done) begin
                            r_cmd_row   <= r_row;
                            r_cmd_col   <= r_col;
                            r_cmd_value <= r_valor;
                            r_cmd_valid <= 1'b1;
                            r_state     <= ENTREGAR;
                        end
                    ENTREGAR:
                        if (i_cmd_ready) begin
                            r_cmd_valid <= 1'b0;
                            r_state     <= OCIOSO;
                        end
                    default: r_state <= OCIOSO;
                endcase
            end
        end
    end

    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_row     = r_cmd_row;
    assign o_cmd_col     = r_cmd_col;
    assign o_cmd_value   = r_cmd_value;
    assign o_erro_pacote = r_erro_pacote;
    assign o_overrun     = r_overrun;
    assign o_erro_count  = r_erro_count;

endmodule

// File: tb/tb_controlador_recepcao_uart.sv
// tb_controlador_recepcao_uart: scoreboard bench for the UART packet receiver controller.
module tb_controlador_recepcao_uart;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_error = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [3:0] cmd_row;
    logic [3:0] cmd_col;
    logic [3:0] cmd_value;
    logic       erro_pacote;
    logic       overrun;
    logic [7:0] erro_count;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] c;
        logic [3:0] v;
    } cmd_t;

    cmd_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int n_erro = 0;
    int n_over = 0;

    controlador_recepcao_uart #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_rx_error   (rx_error),
        .i_cmd_ready  (cmd_ready),
        .o_cmd_valid  (cmd_valid),
        .o_cmd_row    (cmd_row),
        .o_cmd_col    (cmd_col),
        .o_cmd_value  (cmd_value),
        .o_erro_pacote(erro_pacote),
        .o_overrun    (overrun),
        .o_erro_count (erro_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            n_erro += int'(erro_pacote);
            n_over += int'(overrun);
            if (cmd_valid && cmd_ready) begin
                if (sb.size() == 0)
                    check("cmd_unexpected", 1, 0);
                else begin
                    cmd_t e;
                    e = sb.pop_front();
                    check("sb_row", int'(cmd_row), int'(e.r));
                    check("sb_col", int'(cmd_col), int'(e.c));
                    check("sb_value", int'(cmd_value), int'(e.v));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
        rx_data  = b;
        rx_error = err;
        rx_done  = 1'b1;
        @(posedge clk);
        #1;
        rx_done  = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] r, input logic [7:0] c, input logic [7:0] v, input logic [7:0] k);
        send_byte(8'hA5);
        idle(2);
        send_byte(r);
        idle(2);
        send_byte(c);
        idle(2);
        send_byte(v);
        idle(2);
        send_byte(k);
    endtask

    task automatic accept(input logic [3:0] r, input logic [3:0] c, input logic [3:0] v);
        sb.push_back('{r: r, c: c, v: v});
        cmd_ready = 1'b1;
        idle(1);
        cmd_ready = 1'b0;
        check("accept_clears_valid", int'(cmd_valid), 0);
    endtask

    initial begin
        int e0;
        int o0;
        int n;
        idle(3);
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_row", int'(cmd_row), 0);
        check("rst_col", int'(cmd_col), 0);
        check("rst_value", int'(cmd_value), 0);
        check("rst_erro", int'(erro_pacote), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_count", int'(erro_count), 0);
        rst_n = 1'b1;
        idle(2);

        // valid packet, one-clock latency
        send_pkt(8'h03, 8'h07, 8'h05, 8'h01);
        check("lat_valid", int'(cmd_valid), 1);
        check("pkt1_row", int'(cmd_row), 3);
        check("pkt1_col", int'(cmd_col), 7);
        check("pkt1_value", int'(cmd_value), 5);
        check("pkt1_count", int'(erro_count), 0);
        idle(2);
        accept(4'd3, 4'd7, 4'd5);
        idle(2);

        // bad checksum
        e0 = n_erro;
        send_pkt(8'h03, 8'h07, 8'h05, 8'h00);
        idle(3);
        check("badchk_pulses", n_erro - e0, 1);
        check("badchk_valid", int'(cmd_valid), 0);
        check("badchk_count", int'(erro_count), 1);

        // out-of-range row, then trailing bytes, then a boundary packet
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h09);
        check("range_pulse", int'(erro_pacote), 1);
        idle(2);
        send_byte(8'h07);
        idle(2);
        send_byte(8'h05);
        idle(2);
        send_byte(8'h01);
        idle(2);
        check("range_valid", int'(cmd_valid), 0);
        send_pkt(8'h00, 8'h00, 8'h09, 8'h09);
        check("edge_valid", int'(cmd_valid), 1);
        check("edge_count", int'(erro_count), 2);
        accept(4'd0, 4'd0, 4'd9);
        idle(2);

        // timeout after the row byte
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h01);
        n = 0;
        while (!erro_pacote && n < T + 10) begin
            idle(1);
            n++;
        end
        check("timeout_clocks", n, T);
        check("timeout_count", int'(erro_count), 3);
        idle(2);

        // mid-packet SYNC is data, framing error aborts, error in idle ignored
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h01);
        idle(2);
        send_byte(8'hA5);
        check("midsync_pulse", int'(erro_pacote), 1);
        idle(2);
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h03, 1'b1);
        check("rxerr_pulse", int'(erro_pacote), 1);
        check("rxerr_count", int'(erro_count), 5);
        idle(2);
        e0 = n_erro;
        send_byte(8'hA5, 1'b1);
        idle(2);
        send_byte(8'h01);
        idle(2);
        send_byte(8'h02);
        idle(2);
        send_byte(8'h03);
        idle(2);
        send_byte(8'h00);
        idle(2);
        check("idle_err_valid", int'(cmd_valid), 0);
        check("idle_err_pulses", n_erro - e0, 0);

        // overrun while pending, then byte together with ready
        send_pkt(8'h02, 8'h04, 8'h06, 8'h00);
        check("ovr_valid", int'(cmd_valid), 1);
        o0 = n_over;
        idle(2);
        send_byte(8'h11);
        idle(1);
        send_byte(8'hA5);
        idle(2);
        check("ovr_pulses", n_over - o0, 2);
        check("ovr_row", int'(cmd_row), 2);
        check("ovr_col", int'(cmd_col), 4);
        check("ovr_value", int'(cmd_value), 6);
        check("ovr_hold_valid", int'(cmd_valid), 1);
        sb.push_back('{r: 4'd2, c: 4'd4, v: 4'd6});
        cmd_ready = 1'b1;
        send_byte(8'h33);
        cmd_ready = 1'b0;
        check("simul_valid", int'(cmd_valid), 0);
        idle(1);
        check("simul_overrun", n_over - o0, 3);
        idle(2);

        // reset mid-packet discards it silently
        e0 = n_erro;
        send_byte(8'hA5);
        idle(2);
        send_byte(8'h01);
        idle(1);
        rst_n = 1'b0;
        idle(2);
        check("midrst_count", int'(erro_count), 0);
        check("midrst_valid", int'(cmd_valid), 0);
        check("midrst_row", int'(cmd_row), 0);
        rst_n = 1'b1;
        idle(2);
        send_pkt(8'h08, 8'h08, 8'h09, 8'h09);
        check("postrst_valid", int'(cmd_valid), 1);
        accept(4'd8, 4'd8, 4'd9);
        check("postrst_pulses", n_erro - e0, 0);
        idle(2);

        // saturation
        for (int i = 0; i < 260; i++) begin
            send_pkt(8'h01, 8'h01, 8'h01, 8'h00);
            idle(1);
        end
        check("sat_count", int'(erro_count), 255);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controlador_recepcao_uart.md
CONTROLADOR_RECEPCAO_UART -- requirements
Module: controlador_recepcao_uart

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: packet start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: maximum idle clocks allowed between bytes inside a packet.
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_done  input  1  one-clock pulse from UART receiver; rx_data is valid in that cycle.
REQ-006 rx_data  input  8  received byte.
REQ-007 rx_error  input  1  framing error from the UART receiver, qualified by rx_done.
REQ-008 cmd_ready  input  1  consumer accepts the command in any cycle where cmd_valid=1.
REQ-009 cmd_valid  output  1  a decoded command is held on cmd_row, cmd_col and cmd_value.
REQ-010 cmd_row, cmd_col  output  4 each  cell coordinates, range 0..8.
REQ-011 cmd_value  output  4  digit 0..9; 0 clears the cell.
REQ-012 erro_pacote  output  1  one-clock pulse for each discarded packet.
REQ-013 overrun  output  1  one-clock pulse for each byte dropped while a command is pending.
REQ-014 erro_count  output  8  saturating count of erro_pacote pulses.

Function
REQ-015 Packet format: SYNC_BYTE, row, col, value, checksum; checksum = row ^ col ^ value (8-bit XOR).
REQ-016 FSM states: OCIOSO, LINHA, COLUNA, VALOR, CHECKSUM, ENTREGAR.
REQ-017 OCIOSO: advance to LINHA on rx_done with rx_data==SYNC_BYTE and rx_error=0; ignore any other byte silently.
REQ-018 Transitions: LINHA->COLUNA->VALOR->CHECKSUM, one transition per rx_done; each byte is latched into an internal register.
REQ-019 Range checks: row>8, col>8 or value>9 discards the packet at that byte (erro_pacote, go to OCIOSO); the remaining bytes of that packet are then parsed as non-SYNC bytes.
REQ-020 CHECKSUM byte: on match, go to ENTREGAR; on mismatch, pulse erro_pacote and go to OCIOSO.
REQ-021 rx_done with rx_error=1 in any state other than OCIOSO or ENTREGAR: pulse erro_pacote and go to OCIOSO.
REQ-022 Timeout: a 16-bit counter clears on every rx_done and when entering LINHA. It counts in LINHA..CHECKSUM; when it reaches TIMEOUT_CYCLES-1, pulse erro_pacote and go to OCIOSO.
REQ-023 ENTREGAR: cmd_valid=1 with cmd_* stable from the cycle after the checksum byte (latency 1 clock); when cmd_valid=1 and cmd_ready=1, go to OCIOSO next clock.
REQ-024 In ENTREGAR, every rx_done pulses overrun and the byte is dropped; no timeout applies in ENTREGAR.
REQ-025 Simultaneous rx_done and cmd_ready in ENTREGAR: the byte is dropped (overrun) and the command is accepted.
REQ-026 erro_count increments with each erro_pacote pulse and saturates at 255.
REQ-027 cmd_row, cmd_col and cmd_value hold the last delivered command while cmd_valid=0.
REQ-028 A SYNC_BYTE arriving mid-packet is treated as data, not as a resync.

Reset
REQ-029 While reset=0: state=OCIOSO, cmd_valid=0, cmd_row=cmd_col=cmd_value=0, erro_pacote=0, overrun=0, erro_count=0, timeout counter=0.
REQ-030 Reset asserted mid-packet or in ENTREGAR discards all partial or pending data; no erro_pacote pulse is generated.

Structure
REQ-031 State encodings, the default SYNC_BYTE, and the limits 8 (max coordinate) and 9 (max value) belong in a shared package used by both UART controllers.
REQ-032 One sub-module, contador_timeout (counter with clear, enable and terminal flag), implements REQ-022.

Verification
REQ-033 Bytes A5,03,07,05,01 -> cmd_valid=1 one clock after the last rx_done; row=3, col=7, value=5; erro_count=0.
REQ-034 Bytes A5,03,07,05,00 -> one erro_pacote pulse, no cmd_valid, erro_count=1, state back to OCIOSO.
REQ-035 Bytes A5,09,... -> erro_pacote on the 09 byte; a following valid packet A5,00,00,09,09 delivers row=0, col=0, value=9.
REQ-036 A5,01 then TIMEOUT_CYCLES idle clocks -> erro_pacote exactly TIMEOUT_CYCLES clocks after the 01 rx_done.
REQ-037 Valid packet with cmd_ready=0 held, then 2 more bytes -> 2 overrun pulses, cmd_* unchanged; cmd_ready=1 -> cmd_valid=0 next clock.
REQ-038 reset=0 after byte 2 of a packet, then a full valid packet -> only that packet is delivered; 260 bad packets -> erro_count=255.
